// File: rtl/k_and_s_pkg.sv
// Shared types and default widths for the K&S processor memory subsystem.
// The owner enum doubles as the RAM arbiter FSM state (OWN_NONE is its idle state).
package k_and_s_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } arb_owner_t;

endpackage : k_and_s_pkg

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port K&S RAM between the CPU datapath and
// the host port; same-cycle grant, one-cycle registered read-valid return.
module ram_arbiter
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_owner_t       state_q, state_d;
  arb_owner_t       last_q, last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             host_rvalid_q, host_rvalid_d;
  logic             win_cpu, win_host;
  logic             burst_open;

  assign burst_open = (burst_cnt_q < CNT_MAX);

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    win_cpu  = 1'b0;
    win_host = 1'b0;
    unique case (state_q)
      OWN_CPU: begin
        if (cpu_req && (burst_open || !host_req)) win_cpu  = 1'b1;
        else if (host_req)                        win_host = 1'b1;
      end
      OWN_HOST: begin
        if (host_req && (burst_open || !cpu_req)) win_host = 1'b1;
        else if (cpu_req)                         win_cpu  = 1'b1;
      end
      default: begin
        // Contention from idle goes to whoever was not served last.
        if (cpu_req && host_req) begin
          if (last_q == OWN_HOST) win_cpu  = 1'b1;
          else                    win_host = 1'b1;
        end else if (cpu_req) begin
          win_cpu = 1'b1;
        end else if (host_req) begin
          win_host = 1'b1;
        end
      end
    endcase
  end

  // Grants are forced low while reset is held, even though they are combinational.
  assign cpu_gnt  = rst_n & win_cpu;
  assign host_gnt = rst_n & win_host;

  always_comb begin
    state_d       = OWN_NONE;
    burst_cnt_d   = '0;
    last_d        = last_q;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    if (win_cpu) begin
      state_d      = OWN_CPU;
      last_d       = OWN_CPU;
      cpu_rvalid_d = !cpu_we;
      if (state_q == OWN_CPU) burst_cnt_d = burst_open ? burst_cnt_q + CNT_ONE : burst_cnt_q;
      else                    burst_cnt_d = CNT_ONE;
    end else if (win_host) begin
      state_d       = OWN_HOST;
      last_d        = OWN_HOST;
      host_rvalid_d = !host_we;
      if (state_q == OWN_HOST) burst_cnt_d = burst_open ? burst_cnt_q + CNT_ONE : burst_cnt_q;
      else                     burst_cnt_d = CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OWN_NONE;
      last_q        <= OWN_HOST;
      burst_cnt_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign ram_we    = (cpu_gnt & cpu_we) | (host_gnt & host_we);
  assign ram_addr  = host_gnt ? host_addr  : cpu_addr;
  assign ram_wdata = host_gnt ? host_wdata : cpu_wdata;

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = ram_rdata;
  assign host_rdata  = ram_rdata;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random traffic,
// all checked against a streak-based arbitration model and a shadow memory.
module tb_ram_arbiter;
  import k_and_s_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, ram_we;
  logic [DW-1:0] cpu_rdata, host_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous single-port RAM macro seen by the arbiter.
  logic [DW-1:0] ram [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  // Model: who was granted last, how many consecutive cycles in a row, and whether
  // the previous cycle granted anyone at all. -1 = no grant, 0 = CPU, 1 = host.
  int            m_last     = 1;
  bit            m_prev_gnt = 1'b0;
  int            m_run      = 0;
  bit            e_cpu_rv   = 1'b0, e_host_rv = 1'b0;
  logic [DW-1:0] e_cpu_d    = '0,   e_host_d  = '0;
  logic [DW-1:0] shadow [0:255] = '{default: '0};
  int            last_win   = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_prev_gnt = 1'b0; m_run = 0;
    e_cpu_rv = 1'b0; e_host_rv = 1'b0;
  endtask

  function automatic int predict();
    if (!rst_n) return -1;
    if (cpu_req && !host_req) return 0;
    if (host_req && !cpu_req) return 1;
    if (!cpu_req && !host_req) return -1;
    if (m_prev_gnt && m_run < MB) return m_last;
    return 1 - m_last;
  endfunction

  // One clock cycle: inputs are already set (just after a rising edge).
  task automatic step();
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    w  = predict();
    a  = (w == 1) ? host_addr  : cpu_addr;
    d  = (w == 1) ? host_wdata : cpu_wdata;
    we = (w == 0) ? cpu_we : (w == 1) ? host_we : 1'b0;
    @(negedge clk);
    check("cpu_gnt", cpu_gnt, (w == 0));
    check("host_gnt", host_gnt, (w == 1));
    check("ram_we", ram_we, we);
    check("ram_addr", ram_addr, a);
    check("ram_wdata", ram_wdata, d);
    check("cpu_rvalid", cpu_rvalid, e_cpu_rv);
    check("host_rvalid", host_rvalid, e_host_rv);
    if (e_cpu_rv)  check("cpu_rdata", cpu_rdata, e_cpu_d);
    if (e_host_rv) check("host_rdata", host_rdata, e_host_d);
    last_win = w;
    @(posedge clk);
    e_cpu_rv = 1'b0; e_host_rv = 1'b0;
    if (w >= 0) begin
      m_run = (m_prev_gnt && m_last == w) ? m_run + 1 : 1;
      m_last = w;
      m_prev_gnt = 1'b1;
      if (we) shadow[a] = d;
      else if (w == 0) begin e_cpu_rv = 1'b1;  e_cpu_d  = shadow[a]; end
      else             begin e_host_rv = 1'b1; e_host_d = shadow[a]; end
    end else begin
      m_prev_gnt = 1'b0;
      m_run = 0;
    end
    #1;
  endtask

  initial begin
    string seq;
    seq = "CCCCHHHHCCCCHHHH";

    // Reset held with both ports requesting writes.
    cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b1; host_we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    rst_n = 1'b1;

    // Continuous contention: bursts of MB alternate, CPU first.
    cpu_we = 1'b0; host_we = 1'b0; cpu_addr = 8'h01; host_addr = 8'h02;
    for (int i = 0; i < 16; i++) begin
      step();
      check("burst_seq", last_win, (seq[i] == "C") ? 0 : 1);
    end

    // Host preloads 0x10, then the CPU reads it back.
    cpu_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 16'hBEEF;
    step();
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    check("cpu_read_rvalid", cpu_rvalid, 1'b1);
    check("cpu_read_data", cpu_rdata, 16'hBEEF);
    check("cpu_read_host_rvalid", host_rvalid, 1'b0);
    cpu_req = 1'b0;
    step();

    // Host write immediately followed by a CPU read of the same word.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 16'h1234;
    step();
    check("wr_no_host_rvalid", host_rvalid, 1'b0);
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    step();
    check("raw_rvalid", cpu_rvalid, 1'b1);
    check("raw_data", cpu_rdata, 16'h1234);

    // Owner release: CPU drops while host waits, then both idle, then contention.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    cpu_req = 1'b0;
    step();
    check("release_to_host", last_win, 1);
    host_req = 1'b0;
    step();
    check("release_idle", last_win, -1);
    cpu_req = 1'b1; host_req = 1'b1;
    step();
    check("idle_contention_cpu", last_win, 0);

    // Reset pulsed between a CPU read grant and the next edge.
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    check("midrst_gnt", cpu_gnt, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("midrst_gnt_low", cpu_gnt, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_rvalid", cpu_rvalid, 1'b0);
    rst_n = 1'b1;
    cpu_req = 1'b0;
    model_reset();
    step();
    check("postrst_rvalid", cpu_rvalid, 1'b0);
    step();

    // Random traffic; requests are held until granted, occasionally withdrawn.
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req || last_win == 0) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        cpu_req = 1'b0;
      end
      if (!host_req || last_win == 1) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = $urandom_range(0, 1);
        host_addr  = AW'($urandom_range(0, 15));
        host_wdata = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        host_req = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM of the K&S processor between two requesters:
  - the CPU datapath (fetch, load and store accesses);
  - a host port used for program loading and debug peek/poke.
- Round-robin arbitration with a bounded burst length.
- Same-cycle grant, one-cycle registered read-valid return.
- Sits between the datapath memory interface and the RAM macro.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (legal range ≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, held until cpu_gnt
- cpu_we  input  1  CPU write (1) / read (0)
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_gnt  output  1  CPU access accepted this cycle
- cpu_rvalid  output  1  CPU read data valid
- cpu_rdata  output  DATA_W  CPU read data
- host_req, host_we, host_addr, host_wdata  input  1/1/ADDR_W/DATA_W  host equivalents of the CPU inputs
- host_gnt, host_rvalid, host_rdata  output  1/1/DATA_W  host equivalents of the CPU outputs
- ram_addr  output  ADDR_W  RAM address
- ram_we  output  1  RAM write enable
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data, synchronous, valid one cycle after address

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - state=IDLE, burst_cnt=0, last_served=HOST (so the CPU wins the first contention);
  - cpu_rvalid=host_rvalid=0.
- Grant outputs:
  - gnt outputs are combinational from state, burst_cnt, last_served and the req inputs; at most one is high per cycle.
  - All gnt are 0 while rst_n=0.
- RAM drive:
  - In a grant cycle, ram_addr, ram_we and ram_wdata come from the granted port.
  - With no grant: ram_we=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
- FSM states: IDLE, OWN_CPU, OWN_HOST.
  - IDLE:
    - Only one req → grant it; go to OWN_x; burst_cnt=1.
    - Both req → grant the port that is not last_served.
    - None → stay in IDLE.
  - OWN_x:
    - x req and (burst_cnt<MAX_BURST or other not req) → grant x; burst_cnt saturating increment.
    - Else, other req → grant other; go to OWN_other; burst_cnt=1.
    - Else → IDLE, no grant, burst_cnt=0.
- last_served is updated on every grant.
- MAX_BURST=1 gives strict alternation under continuous contention.
- Read return:
  - A read grant sets the port's rvalid register; rvalid is high for exactly the following cycle.
  - Write grants never assert rvalid.
  - cpu_rdata and host_rdata are direct passthroughs of ram_rdata; they are meaningful only while the matching rvalid is high.
- Back-to-back grants to the same port are allowed every cycle; reads are pipelined, one return per cycle.
- A requester may change addr, we or wdata only after gnt; the arbiter does not latch request fields.
- A request deasserted before gnt is dropped with no side effect.
- Reset mid-operation: the pending rvalid is cleared and no rvalid is emitted after reset release for pre-reset grants.
- Burst counter width: $clog2(MAX_BURST+1) bits.

Decomposition:
- Shared package k_and_s_pkg gets:
  - typedef enum arb_owner_t {OWN_NONE, OWN_CPU, OWN_HOST}, used as the FSM state type;
  - constant RAM_ADDR_W=8 and RAM_DATA_W=16 as parameter defaults.
- No sub-module: the port mux and the FSM stay in one module.

Test Plan:
- Reset: assert rst_n=0 with both req high → all gnt, rvalid and ram_we are 0; after release, first cycle with both req → cpu_gnt=1.
- CPU read: ram[0x10]=0xBEEF, cpu_req=1, cpu_we=0, cpu_addr=0x10 → cpu_gnt same cycle, ram_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF; host_rvalid stays 0.
- Host write then CPU read: host write 0x20=0x1234 granted; next cycle cpu read 0x20 → cpu_rvalid with 0x1234, and no host_rvalid for the write.
- Continuous contention, MAX_BURST=4, both req held for 16 cycles → grant sequence C,C,C,C,H,H,H,H,C,C,C,C,H,H,H,H.
- Owner release: in OWN_CPU, cpu_req drops while host_req=1 → host_gnt that same cycle, burst_cnt=1; then both idle → IDLE with no grant.
- Reset mid-read: CPU read granted, rst_n pulsed low before the next edge → cpu_rvalid=0 throughout and after release.
